// File: rtl/bennett_capture.sv
// rtl/bennett_capture.sv - Bennett 8-phase ramp checker with hold-window result capture.
// Optional watchdog on stalled phases: define BENNETT_CAPTURE_TIMEOUT_EN.
module bennett_capture #(
  parameter int WIDTH   = 8,
  parameter int DATA_W  = 16,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           clkp,
  input  logic [WIDTH-1:0]           clkn,
  input  logic                       instFlag,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       cout_in,
  output logic [DATA_W-1:0]          result,
  output logic                       result_cout,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [$clog2(WIDTH+1)-1:0] phase,
  output logic                       err_proto,
  output logic                       err_overrun,
  output logic                       busy
);
  localparam int KW = $clog2(WIDTH+1);
  localparam int SW = $clog2(SETTLE+1);
  localparam logic [KW-1:0] K_FULL = KW'(WIDTH);
  localparam logic [KW-1:0] K_TOP1 = KW'(WIDTH-1);
  localparam logic [SW-1:0] S_DONE = SW'(SETTLE);

  if (SETTLE < 1 || TIMEOUT < 1) begin : g_param_check
    $error("bennett_capture: SETTLE and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_CHARGE, S_HOLD, S_DISCHARGE, S_ERROR} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] clkp_q, clkn_q, clkp_inc;
  logic             flag_q, sample_vld;
  logic [KW-1:0]    k, k_last;
  logic             well_formed, proto_set, capture, timeout, active;
  logic [SW-1:0]    settle_cnt;
  logic             captured;

  // sample_vld masks the all-zero input registers left behind by reset
  always_comb begin
    k = '0;
    for (int i = 0; i < WIDTH; i++) k = k + KW'(clkp_q[i]);
    clkp_inc    = clkp_q + WIDTH'(1);
    well_formed = sample_vld && (clkn_q == ~clkp_q) && ((clkp_q & clkp_inc) == '0);
  end

  assign active = (state == S_CHARGE) || (state == S_HOLD) || (state == S_DISCHARGE);

`ifdef BENNETT_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] wd_cnt;
  assign timeout = active && (k == k_last) && (wd_cnt == TW'(TIMEOUT-1));
  always_ff @(posedge clk) begin
    if (reset || !active || (k != k_last) || (state_next != state)) wd_cnt <= '0;
    else                                                            wd_cnt <= wd_cnt + TW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    proto_set  = 1'b0;
    capture    = 1'b0;
    if (sample_vld && state != S_ERROR && !well_formed) begin
      state_next = S_ERROR;
      proto_set  = 1'b1;
    end else if (sample_vld) begin
      case (state)
        S_IDLE: begin
          if (k == KW'(1))  state_next = S_CHARGE;
          else if (k != '0) begin state_next = S_ERROR; proto_set = 1'b1; end
        end
        S_CHARGE: begin
          if (k == k_last + KW'(1)) begin
            if (k == K_FULL) state_next = S_HOLD;
          end else if (k != k_last) begin
            state_next = S_ERROR; proto_set = 1'b1;
          end
        end
        S_HOLD: begin
          if (k == K_FULL) begin
            capture = flag_q && (settle_cnt == S_DONE) && !captured;
          end else if (k == K_TOP1) begin
            state_next = S_DISCHARGE;
            proto_set  = !captured;
          end else begin
            state_next = S_ERROR; proto_set = 1'b1;
          end
        end
        S_DISCHARGE: begin
          if (k == k_last - KW'(1)) begin
            if (k == '0) state_next = S_IDLE;
          end else if (k != k_last) begin
            state_next = S_ERROR; proto_set = 1'b1;
          end
        end
        default: if (well_formed && k == '0) state_next = S_IDLE;
      endcase
      if (timeout) begin
        state_next = S_ERROR;
        proto_set  = 1'b1;
        capture    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clkp_q       <= '0;
      clkn_q       <= '0;
      flag_q       <= 1'b0;
      sample_vld   <= 1'b0;
      k_last       <= '0;
      settle_cnt   <= '0;
      captured     <= 1'b0;
      result       <= '0;
      result_cout  <= 1'b0;
      result_valid <= 1'b0;
      err_proto    <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      clkp_q     <= clkp;
      clkn_q     <= clkn;
      flag_q     <= instFlag;
      sample_vld <= 1'b1;
      if (well_formed) k_last <= k;
      if (state != S_HOLD || !flag_q) settle_cnt <= '0;
      else if (settle_cnt != S_DONE)  settle_cnt <= settle_cnt + SW'(1);
      if (state != S_HOLD) captured <= 1'b0;
      else if (capture)    captured <= 1'b1;
      if (proto_set) err_proto <= 1'b1;
      // a capture into a full buffer is only accepted when the old entry pops the same cycle
      if (capture && (!result_valid || result_ready)) begin
        result       <= data_in;
        result_cout  <= cout_in;
        result_valid <= 1'b1;
      end else begin
        if (capture) err_overrun <= 1'b1;
        if (result_valid && result_ready) result_valid <= 1'b0;
      end
    end
  end

  assign phase = k_last;
  assign busy  = (state != S_IDLE);
endmodule

// File: tb/tb_bennett_capture.sv
// tb/tb_bennett_capture.sv - directed scoreboard bench for bennett_capture.
module tb_bennett_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  clkp = 8'h00;
  logic [7:0]  clkn = 8'hFF;
  logic        instFlag = 1'b0;
  logic [15:0] data_in = 16'h0;
  logic        cout_in = 1'b0;
  logic        result_ready = 1'b0;
  logic [15:0] result;
  logic        result_cout, result_valid, err_proto, err_overrun, busy;
  logic [3:0]  phase;

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  logic v_at3, v_at4;

  bennett_capture dut (
    .clk(clk), .reset(reset), .clkp(clkp), .clkn(clkn), .instFlag(instFlag),
    .data_in(data_in), .cout_in(cout_in), .result(result), .result_cout(result_cout),
    .result_valid(result_valid), .result_ready(result_ready), .phase(phase),
    .err_proto(err_proto), .err_overrun(err_overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_k(input int k);
    clkp = 8'((9'd1 << k) - 9'd1);
    clkn = ~clkp;
  endtask

  task automatic sb_cmp(input string tag, input bit pop);
    logic [16:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, result);
    end else begin
      e = pop ? exp_q.pop_front() : exp_q[0];
      check({tag, "_data"}, 32'(result), 32'(e[15:0]));
      check({tag, "_cout"}, 32'(result_cout), 32'(e[16]));
    end
  endtask

  task automatic ramp_up(input logic [15:0] d, input logic c, input bit pulse, input bit load);
    data_in = d;
    cout_in = c;
    for (int k = 1; k <= 8; k++) begin set_k(k); tick(4); end
    instFlag = 1'b1;
    tick(3);
    v_at3 = result_valid;
    if (pulse) begin
      sb_cmp("pulse_pop", 1'b1);
      result_ready = 1'b1;
    end
    tick(1);
    result_ready = 1'b0;
    v_at4 = result_valid;
    if (load) exp_q.push_back({c, d});
    tick(2);
    instFlag = 1'b0;
    tick(1);
  endtask

  task automatic ramp_down();
    for (int k = 7; k >= 0; k--) begin set_k(k); tick(4); end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!result_valid && n < 20) begin tick(1); n++; end
    check({tag, "_valid"}, 32'(result_valid), 32'd1);
    if (result_valid) begin
      sb_cmp(tag, 1'b1);
      result_ready = 1'b1;
      tick(1);
      result_ready = 1'b0;
      check({tag, "_clear"}, 32'(result_valid), 32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_cout"}, 32'(result_cout), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_eproto"}, 32'(err_proto), 32'd0);
    check({tag, "_eover"}, 32'(err_overrun), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    tick(2);
    check_zero("reset");
    reset = 1'b0;
    tick(2);

    ramp_up(16'hBEEF, 1'b1, 1'b0, 1'b1);
    check("lat_before", 32'(v_at3), 32'd0);
    check("lat_settle", 32'(v_at4), 32'd1);
    sb_cmp("clean", 1'b0);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_phase", 32'(phase), 32'd8);
    ramp_down();
    check("clean_eproto", 32'(err_proto), 32'd0);
    check("clean_eover", 32'(err_overrun), 32'd0);
    check("clean_idle", 32'(busy), 32'd0);
    check("clean_phase0", 32'(phase), 32'd0);
    drain("clean_pop");

    ramp_up(16'h0001, 1'b0, 1'b0, 1'b1);
    ramp_down();
    ramp_up(16'h0002, 1'b0, 1'b0, 1'b0);
    ramp_down();
    check("overrun_set", 32'(err_overrun), 32'd1);
    sb_cmp("keep_old", 1'b0);
    drain("overrun_pop");

    pulse_reset();
    ramp_up(16'h0001, 1'b0, 1'b0, 1'b1);
    ramp_down();
    ramp_up(16'h0002, 1'b0, 1'b1, 1'b1);
    ramp_down();
    check("swap_eover", 32'(err_overrun), 32'd0);
    check("swap_eproto", 32'(err_proto), 32'd0);
    drain("swap_pop");

    for (int k = 1; k <= 3; k++) begin set_k(k); tick(4); end
    check("skip_phase3", 32'(phase), 32'd3);
    set_k(5);
    tick(3);
    check("skip_eproto", 32'(err_proto), 32'd1);
    check("skip_busy", 32'(busy), 32'd1);
    set_k(0);
    tick(3);
    check("skip_recover", 32'(busy), 32'd0);
    ramp_up(16'h1234, 1'b1, 1'b0, 1'b1);
    ramp_down();
    check("skip_idle", 32'(busy), 32'd0);
    check("skip_eover", 32'(err_overrun), 32'd0);
    drain("skip_pop");

    pulse_reset();
    check("cpl_pre", 32'(err_proto), 32'd0);
    clkp = 8'h0F;
    clkn = 8'hF1;
    tick(3);
    check("cpl_eproto", 32'(err_proto), 32'd1);
    set_k(0);
    tick(3);
    check("cpl_recover", 32'(busy), 32'd0);

    pulse_reset();
    ramp_up(16'h5555, 1'b1, 1'b0, 1'b1);
    check("mid_valid", 32'(result_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    check_zero("mid_reset");
    reset = 1'b0;
    exp_q.delete();
    tick(3);
    check("mid_eproto", 32'(err_proto), 32'd1);
    check("mid_busy", 32'(busy), 32'd1);
    ramp_down();
    check("mid_recover", 32'(busy), 32'd0);

    pulse_reset();
    for (int k = 1; k <= 4; k++) begin set_k(k); tick(4); end
    tick(70);
`ifdef BENNETT_CAPTURE_TIMEOUT_EN
    check("stall_eproto", 32'(err_proto), 32'd1);
`else
    check("stall_eproto", 32'(err_proto), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_phase", 32'(phase), 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bennett_capture.md
Name: bennett_capture

Overview:
- Receive-side companion to the Bennett clock generator and adiabatic adder datapath.
- Monitors the 8-phase clkp/clkn ramp sequence and checks it against the Bennett protocol: thermometer charge up, hold, reverse discharge.
- Latches the adder result during the hold window and presents it downstream on a single-entry valid/ready buffer.
- Flags protocol violations and overruns as sticky errors.

Parameters:
- WIDTH, 8, number of Bennett clock phases (clkp/clkn width).
- DATA_W, 16, adder result width.
- SETTLE, 2, clk cycles instFlag must stay high in HOLD before capture.
- TIMEOUT, 64, max clk cycles without a phase change (optional feature only).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- clkp  input  WIDTH  positive Bennett phases from generator
- clkn  input  WIDTH  negative Bennett phases from generator
- instFlag  input  1  generator hold/computation-done flag
- data_in  input  DATA_W  adder out bus
- cout_in  input  1  adder carry out
- result  output  DATA_W  captured sum
- result_cout  output  1  captured carry
- result_valid  output  1  buffer holds unread result
- result_ready  input  1  downstream accepts result
- phase  output  $clog2(WIDTH+1)  current count of asserted clkp bits (0..WIDTH)
- err_proto  output  1  sticky protocol violation
- err_overrun  output  1  sticky capture-while-full
- busy  output  1  FSM not in IDLE

Behaviour:
- Inputs are registered once before checking, so all decisions use 1-cycle-delayed samples.
- Well-formed sample: clkn == ~clkp, and clkp is a thermometer code (bits 0..k-1 set, rest clear); k drives phase.
- Any malformed sample in any state except ERROR: go to ERROR and set err_proto.
- States and transitions:
  - IDLE: expect k=0. k goes 0->1: CHARGE. Any other change of k: ERROR.
  - CHARGE: k may hold or increase by exactly 1. Decrease or jump >1: ERROR. k==WIDTH: HOLD, settle counter cleared.
  - HOLD: k must stay WIDTH.
    - While instFlag=1, the settle counter increments.
    - When the counter reaches SETTLE, capture data_in/cout_in exactly once per ramp.
    - instFlag low before capture is legal; no capture happens and the counter resets.
    - k->WIDTH-1: DISCHARGE. Any other change: ERROR.
    - Reaching DISCHARGE without a capture sets err_proto.
  - DISCHARGE: k may hold or decrease by exactly 1; increase or jump: ERROR. k==0: IDLE.
  - ERROR: holds until a well-formed k=0 sample is seen, then IDLE. err_proto stays set.
- Capture and output buffer:
  - Capture with result_valid=0: load result/result_cout, set result_valid next cycle.
  - Capture with result_valid=1 and result_ready=1 in the same cycle: pop old, load new; result_valid stays 1; no overrun.
  - Capture with result_valid=1 and result_ready=0: drop new data, keep old, set err_overrun.
  - Handshake: result_valid && result_ready pops; result_valid clears next cycle unless a simultaneous capture reloads it.
  - result is stable while result_valid=1 and not popped.
- Reset (synchronous, any state, including mid-ramp):
  - FSM to IDLE; result=0, result_cout=0, result_valid=0, phase=0, err_proto=0, err_overrun=0, busy=0; input registers and counters cleared.
  - A ramp already in progress after reset is seen as k!=0 in IDLE and flagged as ERROR.
- Latency: data_in sampled at the capture clock edge. result_valid asserts 1 cycle after the registered sample satisfies the SETTLE count, i.e. SETTLE+2 cycles after instFlag rises with k==WIDTH.

Optional Feature:
- Macro BENNETT_CAPTURE_TIMEOUT_EN.
- Defined:
  - Watchdog counts clk cycles in CHARGE, HOLD and DISCHARGE without a change of k; resets on any k change or state change.
  - On reaching TIMEOUT: go to ERROR, set err_proto.
  - IDLE and ERROR are never timed out.
- Undefined: no watchdog logic; a stalled generator leaves the FSM waiting indefinitely. TIMEOUT is unused.

Test Plan:
- Clean ramp: k 0..8 one step per 4 cycles, instFlag=1 for 6 cycles in HOLD, data_in=16'hBEEF, cout_in=1, result_ready=0 -> result=16'hBEEF, result_cout=1, result_valid=1 at SETTLE+2 cycles after instFlag rise; errors 0; returns to IDLE at k=0.
- Back-to-back ramps, data 16'h0001 then 16'h0002, result_ready held 0 -> result stays 16'h0001, err_overrun=1 after the second capture. Repeat with result_ready pulsed in the capture cycle -> result=16'h0002, err_overrun=0.
- Skip stage: k jumps 3->5 in CHARGE -> ERROR, err_proto=1. Then k=0 well-formed -> IDLE, and the next clean ramp captures normally.
- Complement fault: clkp=8'h0F, clkn=8'hF1 -> err_proto=1.
- Reset asserted mid-HOLD with result_valid=1 -> all outputs 0 the next cycle. Generator still at k=8 -> ERROR, err_proto=1.
- With BENNETT_CAPTURE_TIMEOUT_EN: stall at k=4 for 64 cycles -> err_proto=1 on cycle 64. Without the macro -> no error, busy stays 1.
